spi_controller: RTL and testbench

Single-clock SPI controller that drives the SCK/CS/COPI side of the team's 16-bit write-then-read SPI link and captures the peripheral's reply on CIPO. It sits in the digital buck controller's clock domain, between register/command logic and the off-chip or on-die SPI peripheral. It generates one complete frame per `start` request: LENGTH_SEND bits out, one turnaround pulse, LENGTH_RECEIVED bits in, then CS release and an inter-frame pause.

---
 rtl/spi_controller.sv | 136 +++++++++++++
 tb/tb_spi_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI controller for the 16-bit write-then-read link (send, turnaround, receive)
module spi_controller #(
    parameter int LENGTH_SEND     = 16,
    parameter int LENGTH_RECEIVED = 16,
    parameter int CLK_DIV         = 4,
    parameter int PAUSE           = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LENGTH_SEND-1:0]     tx_data,
    output logic                       busy,
    output logic                       done,
    output logic [LENGTH_RECEIVED-1:0] rx_data,
    output logic                       SCK,
    output logic                       CS,
    output logic                       COPI,
    input  logic                       CIPO
);
    localparam int N  = LENGTH_SEND + LENGTH_RECEIVED + 1;
    localparam int CW = $clog2(N + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int PW = (PAUSE > 0) ? $clog2(PAUSE + 1) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

    state_t                     state;
    logic [CW-1:0]              pulse_cnt;
    logic [DW-1:0]              div_cnt;
    logic [PW-1:0]              pause_cnt;
    logic [LENGTH_SEND-1:0]     tx_sh;
    logic [LENGTH_SEND-1:0]     tx_next;
    logic [LENGTH_RECEIVED-1:0] rx_sh;
    logic                       div_end;
    logic                       pause_end;
    logic                       accept;

    assign tx_next   = tx_sh >> 1;
    assign div_end   = (div_cnt == DW'(CLK_DIV - 1));
    assign pause_end = (PAUSE == 0) || (pause_cnt == PW'(PAUSE - 1));
    // A start held high is taken on the last GAP cycle so frames run back to back
    assign accept    = start && ((state == IDLE) || ((state == GAP) && pause_end));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            CS        <= 1'b1;
            SCK       <= 1'b0;
            COPI      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rx_data   <= '0;
            pulse_cnt <= '0;
            div_cnt   <= '0;
            pause_cnt <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state     <= SETUP;
                tx_sh     <= tx_data;
                COPI      <= tx_data[0];
                CS        <= 1'b0;
                busy      <= 1'b1;
                div_cnt   <= '0;
                pulse_cnt <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    SETUP: begin
                        if (div_end) begin
                            SCK       <= 1'b1;
                            pulse_cnt <= CW'(1);
                            div_cnt   <= '0;
                            state     <= SHIFT_HI;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    SHIFT_HI: begin
                        if (div_end) begin
                            SCK     <= 1'b0;
                            div_cnt <= '0;
                            tx_sh   <= tx_next;
                            COPI    <= (pulse_cnt < CW'(LENGTH_SEND)) ? tx_next[0] : 1'b0;
                            state   <= (pulse_cnt == CW'(N)) ? HOLD : SHIFT_LO;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    SHIFT_LO: begin
                        if (div_end) begin
                            SCK       <= 1'b1;
                            div_cnt   <= '0;
                            pulse_cnt <= pulse_cnt + 1'b1;
                            // Rising pulses past the turnaround carry reply bits, LSB first
                            if (pulse_cnt >= CW'(LENGTH_SEND + 1))
                                rx_sh <= (rx_sh >> 1) |
                                         (LENGTH_RECEIVED'(CIPO) << (LENGTH_RECEIVED - 1));
                            state <= SHIFT_HI;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (div_end) begin
                            CS        <= 1'b1;
                            rx_data   <= rx_sh;
                            done      <= 1'b1;
                            div_cnt   <= '0;
                            pause_cnt <= '0;
                            if (PAUSE == 0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (pause_end) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            pause_cnt <= pause_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - scoreboard bench for spi_controller with two SPI peripheral models
module tb_spi_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start = 2'b00;
    logic [1:0]  busy, done, sck, cs, copi, cipo;
    logic [15:0] tx[2];
    logic [15:0] rx[2];
    logic [15:0] ds[2];
    logic [1:0][15:0] per_word;

    typedef struct {
        int          unit;
        logic [15:0] rx;
        logic [15:0] tx;
        int          t_done;
    } exp_t;
    exp_t sb[$];

    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    int   n_done = 0;
    int   n_push = 0;
    int   rises[2];
    int   cs_rise0 = -1;
    bit   b2b = 1'b0;
    logic [1:0] sck_prev = 2'b00;
    logic [1:0] cs_prev = 2'b00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_controller u_dut (
        .clk(clk), .rst(rst), .start(start[0]), .tx_data(tx[0]), .busy(busy[0]),
        .done(done[0]), .rx_data(rx[0]), .SCK(sck[0]), .CS(cs[0]), .COPI(copi[0]), .CIPO(cipo[0])
    );

    spi_controller #(.CLK_DIV(1), .PAUSE(0)) u_fast (
        .clk(clk), .rst(rst), .start(start[1]), .tx_data(tx[1]), .busy(busy[1]),
        .done(done[1]), .rx_data(rx[1]), .SCK(sck[1]), .CS(cs[1]), .COPI(copi[1]), .CIPO(cipo[1])
    );

    // Peripheral: 16 bits in on rises, turnaround pulse 17, reply bits put out on falls from pulse 17
    for (genvar g = 0; g < 2; g++) begin : g_per
        int          cnt = 0;
        logic [15:0] rreg = '0;
        logic        c = 1'b0;
        always @(posedge sck[g] or posedge cs[g]) begin
            if (cs[g]) begin
                cnt = 0;
            end else begin
                if (cnt < 16) rreg[4'(cnt)] = copi[g];
                cnt = cnt + 1;
            end
        end
        always @(negedge sck[g]) begin
            if (!cs[g] && cnt >= 17 && cnt < 33) c = ds[g][4'(cnt - 17)];
        end
        assign cipo[g]     = c;
        assign per_word[g] = rreg;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (sck[u] === 1'b1 && sck_prev[u] === 1'b0) rises[u]++;
            if (cs[u] === 1'b0 && cs_prev[u] === 1'b1) begin
                if (b2b && u == 0 && cs_rise0 >= 0) check_eq("cs_gap", cyc - cs_rise0, 10);
                rises[u] = 0;
            end
            if (u == 0 && cs[u] === 1'b1 && cs_prev[u] === 1'b0) cs_rise0 = cyc;
            if (done[u] === 1'b1) begin
                n_done++;
                if (sb.size() == 0) begin
                    check_eq("spurious_done", done[u], 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("done_unit", u, e.unit);
                    check_eq("rx_data", rx[u], e.rx);
                    check_eq("periph_word", per_word[u], e.tx);
                    check_eq("done_time", cyc, e.t_done);
                    check_eq("sck_rises", rises[u], 33);
                    check_eq("cs_at_done", cs[u], 1);
                end
            end
        end
        sck_prev = sck;
        cs_prev  = cs;
    end

    task automatic wait_idle(input int u);
        int n = 0;
        while (busy[u] !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_wait", busy[u], 0);
    endtask

    task automatic run_frame(input int u, input logic [15:0] txv, input logic [15:0] dsv, input int poke);
        int t0, lat, bl;
        lat = (u == 0) ? 268 : 67;
        bl  = (u == 0) ? 278 : 67;
        wait_idle(u);
        ds[u] = dsv;
        tx[u] = txv;
        start[u] = 1'b1;
        t0 = cyc + 1;
        sb.push_back('{u, dsv, txv, t0 + lat});
        n_push++;
        @(negedge clk);
        start[u] = 1'b0;
        check_eq("cs_low", cs[u], 0);
        check_eq("busy_high", busy[u], 1);
        check_eq("copi_bit0", copi[u], txv[0]);
        check_eq("sck_idle", sck[u], 0);
        while (cyc < t0 + bl) begin
            @(negedge clk);
            if (poke > 0 && cyc == t0 + poke - 1) begin
                start[u] = 1'b1;
                tx[u] = 16'hFFFF;
            end else begin
                start[u] = 1'b0;
            end
            if (cyc == t0 + bl - 1) check_eq("busy_before_end", busy[u], 1);
        end
        check_eq("busy_low_time", busy[u], 0);
        tx[u] = txv;
    endtask

    initial begin
        tx[0] = '0; tx[1] = '0; ds[0] = '0; ds[1] = '0;
        rises[0] = 0; rises[1] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_cs", cs[0], 1);
        check_eq("rst_sck", sck[0], 0);
        check_eq("rst_copi", copi[0], 0);
        check_eq("rst_busy", busy[0], 0);
        check_eq("rst_done", done[0], 0);
        check_eq("rst_rx", rx[0], 0);
        check_eq("rst_fast_cs", cs[1], 1);

        run_frame(0, 16'hA5C3, 16'h1234, 0);
        run_frame(0, 16'hA5C3, 16'h1234, 50);

        begin : back_to_back
            int t0;
            wait_idle(0);
            b2b = 1'b1;
            cs_rise0 = -1;
            tx[0] = 16'h5A0F;
            ds[0] = 16'h0F0F;
            start[0] = 1'b1;
            t0 = cyc + 1;
            for (int i = 0; i < 4; i++) begin
                sb.push_back('{0, 16'h0F0F, 16'h5A0F, t0 + 278 * i + 268});
                n_push++;
            end
            repeat (1000) @(negedge clk);
            start[0] = 1'b0;
            wait_idle(0);
            b2b = 1'b0;
        end

        begin : reset_mid_frame
            int t0;
            wait_idle(0);
            tx[0] = 16'h0F0F;
            ds[0] = 16'h7777;
            start[0] = 1'b1;
            t0 = cyc + 1;
            @(negedge clk);
            start[0] = 1'b0;
            while (cyc < t0 + 99) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_eq("mid_rst_cs", cs[0], 1);
            check_eq("mid_rst_sck", sck[0], 0);
            check_eq("mid_rst_busy", busy[0], 0);
            check_eq("mid_rst_rx", rx[0], 0);
            check_eq("mid_rst_done", done[0], 0);
        end
        run_frame(0, 16'h3C5B, 16'hBEEF, 0);
        run_frame(0, 16'h3C5B, 16'h5555, 0);

        run_frame(1, 16'h0001, 16'hFFFF, 0);
        run_frame(1, 16'h8000, 16'h0000, 0);

        repeat (5) @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);
        check_eq("done_count", n_done, n_push);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got cycle %0d expected finish earlier", cyc);
        $fatal(1, "watchdog");
    end
endmodule
